// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, 16x oversampling with a 7/8/9 majority vote.
// Received bytes go into a one-entry valid/ready buffer. The receiver pulses
// frame_err when the stop bit is low, and pulses overrun when a completed byte
// is dropped because the buffer was still full.
module uart_rx #(
    parameter int CLKS_PER_TICK = 54,
    parameter int OVERSAMPLE    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV_W  = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKS_PER_TICK - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    // The three majority samples sit just past mid-bit. The decision is made on the last one.
    localparam logic [SAMP_W-1:0] SAMP_A    = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_B    = SAMP_W'(OVERSAMPLE / 2);
    localparam logic [SAMP_W-1:0] SAMP_DEC  = SAMP_W'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        sync_reg;
    logic [DIV_W-1:0]  div_reg, div_next;
    logic [SAMP_W-1:0] samp_reg, samp_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic [7:0]        shift_reg, shift_next;
    logic              samp_a_reg, samp_a_next;
    logic              samp_b_reg, samp_b_next;
    logic [7:0]        rx_data_reg;
    logic              rx_valid_reg;
    logic              frame_err_reg;
    logic              overrun_reg;

    logic rxs;
    logic tick;
    logic decide;
    logic wrap;
    logic maj;
    logic deliver;
    logic ferr;

    assign rxs    = sync_reg[1];
    assign tick   = (div_reg == DIV_LAST);
    assign decide = tick && (samp_reg == SAMP_DEC);
    assign wrap   = tick && (samp_reg == SAMP_LAST);
    assign maj    = (samp_a_reg & samp_b_reg) | (samp_a_reg & rxs) | (samp_b_reg & rxs);

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    // Next-state logic: tick divider, sample counter, bit assembly and frame sequencing
    always_comb begin
        state_next   = state_reg;
        div_next     = tick ? '0 : div_reg + DIV_W'(1);
        samp_next    = tick ? samp_reg + SAMP_W'(1) : samp_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        samp_a_next  = (tick && samp_reg == SAMP_A) ? rxs : samp_a_reg;
        samp_b_next  = (tick && samp_reg == SAMP_B) ? rxs : samp_b_reg;
        deliver      = 1'b0;
        ferr         = 1'b0;
        case (state_reg)
            IDLE: begin
                // Holding the counters at zero aligns tick phase to the start edge.
                div_next  = '0;
                samp_next = '0;
                if (!rxs) begin
                    state_next   = START;
                    bit_idx_next = 3'd0;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_next = IDLE;
                end else if (wrap) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_next = {maj, shift_reg[7:1]};
                end
                if (wrap) begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leaving at mid stop bit lets a back-to-back start edge be caught.
                if (decide) begin
                    if (maj) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr       = 1'b1;
                        state_next = BRK;
                    end
                end
            end
            BRK: begin
                // A line held low must return high before a new frame can start.
                div_next  = '0;
                samp_next = '0;
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Register the FSM state, the counters and the shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            div_reg     <= '0;
            samp_reg    <= '0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'h00;
            samp_a_reg  <= 1'b1;
            samp_b_reg  <= 1'b1;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            samp_reg    <= samp_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            samp_a_reg  <= samp_a_next;
            samp_b_reg  <= samp_b_next;
        end
    end

    // One-entry output buffer with overrun detection and single-cycle flag pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_reg   <= 8'h00;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= ferr;
            overrun_reg   <= deliver && rx_valid_reg && !rx_ready;
            if (deliver) begin
                if (!rx_valid_reg || rx_ready) begin
                    rx_data_reg  <= shift_reg;
                    rx_valid_reg <= 1'b1;
                end
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg != IDLE);

endmodule
